// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB completer with a byte-wide register memory, programmable wait states,
// error signalling on bad accesses and a saturating completed-transfer counter.
//
// Ports:
//   PCLK     in   clock, all state changes on the rising edge
//   PRESET   in   asynchronous active-high reset
//   PSEL     in   select from the bridge
//   PENABLE  in   access-phase strobe
//   PWRITE   in   1 = write, 0 = read
//   PADDR    in   [8] is the bridge's slave decode (ignored), [7:0] is the local address
//   PWDATA   in   write data
//   PRDATA   out  read data, registered in the setup phase
//   PREADY   out  transfer-complete strobe
//   PSLVERR  out  error, valid only while PREADY is high
//   xfer_cnt out  completed-transfer counter, saturating at 16'hFFFF
//
// Optional feature: define APB_SLV_WPROT_EN to make writes to local addresses >= WPROT_BASE
// complete with PSLVERR and leave memory unchanged.
module apb_slave_mem #(
    parameter int          DATA_W      = 8,
    parameter int          MEM_DEPTH   = 256,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [7:0]  WPROT_BASE  = 8'hF0
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [8:0]        PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [15:0]       xfer_cnt
);
    localparam int AW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
`ifdef APB_SLV_WPROT_EN
    localparam logic WPROT = 1'b1;
`else
    localparam logic WPROT = 1'b0;
`endif

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state, state_n;
    logic [3:0]        cnt, cnt_n;
    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [AW-1:0]     idx;
    logic              in_range, err, setup;
    logic              unused_ok;

    assign unused_ok = PADDR[8];
    assign idx       = PADDR[AW-1:0];
    assign in_range  = {1'b0, PADDR[7:0]} < 9'(MEM_DEPTH);
    // Protection only applies to writes; out-of-range already errors regardless of direction.
    assign err       = ~in_range | (WPROT & PWRITE & (PADDR[7:0] >= WPROT_BASE));
    assign setup     = PSEL & ~PENABLE;
    assign PREADY    = (state == ACCESS) & (cnt == 4'd0) & PSEL & PENABLE;
    assign PSLVERR   = PREADY & err;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (state == IDLE) begin
            if (setup) begin
                state_n = ACCESS;
                cnt_n   = 4'(WAIT_CYCLES);
            end
        end else if (!PSEL) begin
            state_n = IDLE;
        end else if (cnt != 4'd0) begin
            cnt_n = cnt - 4'd1;
        end else if (PREADY) begin
            state_n = IDLE;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            PRDATA   <= '0;
            xfer_cnt <= 16'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (state == IDLE && setup)
                PRDATA <= in_range ? mem[idx] : '0;
            if (PREADY && xfer_cnt != 16'hFFFF)
                xfer_cnt <= xfer_cnt + 16'd1;
        end
    end

    // Memory is not reset; a reset coinciding with PREADY suppresses the write.
    always_ff @(posedge PCLK) begin
        if (PREADY && PWRITE && !err && !PRESET)
            mem[idx] <= PWDATA;
    end
endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: directed bench for apb_slave_mem using a zero-wait 128-deep instance (a)
// and a three-wait 256-deep instance (b) sharing one APB bus with separate selects.
module tb_apb_slave_mem;
    logic        PCLK = 1'b0, PRESET = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic        psel_a = 1'b0, psel_b = 1'b0;
    logic [8:0]  PADDR = '0;
    logic [7:0]  PWDATA = '0;
    logic [7:0]  prdata_a, prdata_b;
    logic        pready_a, pready_b, pslverr_a, pslverr_b;
    logic [15:0] xfer_cnt_a, xfer_cnt_b;
    int          checks = 0, errors = 0;

    always #5 PCLK = ~PCLK;

    apb_slave_mem #(.DATA_W(8), .MEM_DEPTH(128), .WAIT_CYCLES(0), .WPROT_BASE(8'hF0)) dut_a (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel_a), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata_a), .PREADY(pready_a),
        .PSLVERR(pslverr_a), .xfer_cnt(xfer_cnt_a));

    apb_slave_mem #(.DATA_W(8), .MEM_DEPTH(256), .WAIT_CYCLES(3), .WPROT_BASE(8'hF0)) dut_b (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel_b), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata_b), .PREADY(pready_b),
        .PSLVERR(pslverr_b), .xfer_cnt(xfer_cnt_b));

    typedef struct {
        bit         b;
        bit         w;
        logic [8:0] a;
        logic [7:0] d;
        logic [7:0] exp_rd;
        bit         exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full transfer; returns data/error sampled in the PREADY cycle, the number of
    // access cycles with PREADY low, and whether PREADY showed up again while PSEL and
    // PENABLE were held one extra cycle (it must not: no new setup phase occurred).
    task automatic xfer(input bit b, input bit w, input logic [8:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output logic er, output int waits, output logic again);
        @(posedge PCLK); #1;
        psel_a = ~b; psel_b = b; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        waits = 0;
        rd = '0; er = 1'b0;
        forever begin
            @(negedge PCLK);
            if (b ? pready_b : pready_a) break;
            waits++;
            if (waits > 20) begin
                chk("ready_timeout", 32'(waits), 32'd0);
                break;
            end
        end
        rd = b ? prdata_b : prdata_a;
        er = b ? pslverr_b : pslverr_a;
        @(negedge PCLK);
        again = b ? pready_b : pready_a;
        #1;
        psel_a = 1'b0; psel_b = 1'b0; PENABLE = 1'b0;
    endtask

    initial begin
        vec_t       v [14];
        logic [7:0] rd, old;
        logic       er, again;
        int         waits;

        v[0]  = '{0, 1, 9'h010, 8'h3C, 8'h00, 0};
        v[1]  = '{0, 1, 9'h012, 8'hA5, 8'h00, 0};
        v[2]  = '{0, 0, 9'h012, 8'h00, 8'hA5, 0};
        v[3]  = '{0, 0, 9'h090, 8'h00, 8'h00, 1};
        v[4]  = '{0, 1, 9'h090, 8'h5A, 8'h00, 1};
        v[5]  = '{0, 0, 9'h010, 8'h00, 8'h3C, 0};
        v[6]  = '{0, 0, 9'h112, 8'h00, 8'hA5, 0};
        v[7]  = '{0, 1, 9'h07F, 8'hFF, 8'h00, 0};
        v[8]  = '{0, 0, 9'h07F, 8'h00, 8'hFF, 0};
        v[9]  = '{0, 0, 9'h080, 8'h00, 8'h00, 1};
        v[10] = '{1, 1, 9'h020, 8'h33, 8'h00, 0};
        v[11] = '{1, 0, 9'h020, 8'h00, 8'h33, 0};
        v[12] = '{1, 1, 9'h0EF, 8'h11, 8'h00, 0};
        v[13] = '{1, 0, 9'h0EF, 8'h00, 8'h11, 0};

        #3 PRESET = 1'b1;
        #2;
        chk("rst_pready_a", 32'(pready_a), 32'd0);
        chk("rst_pslverr_a", 32'(pslverr_a), 32'd0);
        chk("rst_prdata_a", 32'(prdata_a), 32'd0);
        chk("rst_cnt_a", 32'(xfer_cnt_a), 32'd0);
        chk("rst_cnt_b", 32'(xfer_cnt_b), 32'd0);
        repeat (2) @(posedge PCLK);
        #1 PRESET = 1'b0;

        for (int i = 0; i < 14; i++) begin
            xfer(v[i].b, v[i].w, v[i].a, v[i].d, rd, er, waits, again);
            chk($sformatf("v%0d_err", i), 32'(er), 32'(v[i].exp_err));
            chk($sformatf("v%0d_waits", i), 32'(waits), v[i].b ? 32'd3 : 32'd0);
            chk($sformatf("v%0d_single_ready", i), 32'(again), 32'd0);
            if (!v[i].w) chk($sformatf("v%0d_rdata", i), 32'(rd), 32'(v[i].exp_rd));
        end
        chk("cnt_a_after_table", 32'(xfer_cnt_a), 32'd10);
        chk("cnt_b_after_table", 32'(xfer_cnt_b), 32'd4);

        // Abort: drop PSEL in the second access cycle of a waited write.
        @(posedge PCLK); #1;
        psel_b = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 9'h020; PWDATA = 8'h44;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        @(posedge PCLK); #1 psel_b = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        chk("abort_pready", 32'(pready_b), 32'd0);
        repeat (2) @(posedge PCLK);
        #1;
        chk("abort_cnt", 32'(xfer_cnt_b), 32'd4);
        xfer(1, 0, 9'h020, 8'h00, rd, er, waits, again);
        chk("abort_mem", 32'(rd), 32'h33);
        chk("abort_then_read_waits", 32'(waits), 32'd3);

        // Asynchronous reset in the middle of a wait sequence.
        @(posedge PCLK); #1;
        psel_b = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 9'h020;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        @(negedge PCLK);
        chk("pre_rst_prdata_b", 32'(prdata_b), 32'h33);
        #2 PRESET = 1'b1;
        #1;
        chk("mid_rst_pready_b", 32'(pready_b), 32'd0);
        chk("mid_rst_pslverr_b", 32'(pslverr_b), 32'd0);
        chk("mid_rst_prdata_b", 32'(prdata_b), 32'd0);
        chk("mid_rst_cnt_b", 32'(xfer_cnt_b), 32'd0);
        chk("mid_rst_cnt_a", 32'(xfer_cnt_a), 32'd0);
        #1 psel_b = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1 PRESET = 1'b0;
        xfer(1, 1, 9'h030, 8'h9C, rd, er, waits, again);
        chk("post_rst_wr_err", 32'(er), 32'd0);
        xfer(1, 0, 9'h030, 8'h00, rd, er, waits, again);
        chk("post_rst_rd", 32'(rd), 32'h9C);
        chk("post_rst_cnt_b", 32'(xfer_cnt_b), 32'd2);

        // Write-protected region.
        xfer(1, 0, 9'h0F4, 8'h00, old, er, waits, again);
        xfer(1, 1, 9'h0F4, 8'h77, rd, er, waits, again);
`ifdef APB_SLV_WPROT_EN
        chk("wprot_err", 32'(er), 32'd1);
        xfer(1, 0, 9'h0F4, 8'h00, rd, er, waits, again);
        chk("wprot_readback", 32'(rd), 32'(old));
`else
        chk("wprot_err", 32'(er), 32'd0);
        xfer(1, 0, 9'h0F4, 8'h00, rd, er, waits, again);
        chk("wprot_readback", 32'(rd), 32'h77);
`endif
        chk("wprot_read_err", 32'(er), 32'd0);
        chk("final_cnt_b", 32'(xfer_cnt_b), 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
